// File: rtl/alu_mult_seq_if.sv
// Port bundle between the multiply sequencer and its surroundings: request/response
// handshakes plus the shared-ALU drive and return path.
interface alu_mult_seq_if #(
    parameter int WORD_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;
    logic              abort;
    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] prod_hi;
    logic [WORD_W-1:0] prod_lo;
    logic              busy;
    logic [3:0]        alu_op;
    logic [WORD_W-1:0] alu_port_a;
    logic [WORD_W-1:0] alu_port_b;
    logic [WORD_W-1:0] alu_result;
    logic              alu_overflow;

    // Execute-stage side: issues requests, consumes products, closes the ALU loop.
    modport master (
        output req_valid, op_a, op_b, abort, resp_ready, alu_result, alu_overflow,
        input  req_ready, resp_valid, prod_hi, prod_lo, busy, alu_op, alu_port_a, alu_port_b
    );

    modport slave (
        input  req_valid, op_a, op_b, abort, resp_ready, alu_result, alu_overflow,
        output req_ready, resp_valid, prod_hi, prod_lo, busy, alu_op, alu_port_a, alu_port_b
    );
endinterface

// File: rtl/alu_mult_seq.sv
// Unsigned WORD_W x WORD_W shift-and-add multiplier that borrows the shared
// single-cycle ALU for one add per clock while busy.
module alu_mult_seq #(
    parameter int WORD_W = 32,
    parameter int ITER   = WORD_W
) (
    input  logic            CLK,
    input  logic            nRST,
    alu_mult_seq_if.slave   bus
);
    localparam int              CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(ITER - 1);
    localparam logic [3:0]      ALU_ADD = 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] hi;
    logic [WORD_W-1:0] lo;
    logic [WORD_W-1:0] mcand;
    logic [CNT_W-1:0]  count;
    logic              resp_valid;
    logic              busy;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            hi         <= '0;
            lo         <= '0;
            mcand      <= '0;
            count      <= '0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // An accept outranks a simultaneous abort here.
                    if (bus.req_valid) begin
                        mcand <= bus.op_a;
                        hi    <= '0;
                        lo    <= bus.op_b;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        // {carry, sum, lo} shifted right by one: the sum's LSB drops into lo.
                        hi    <= {bus.alu_overflow, bus.alu_result[WORD_W-1:1]};
                        lo    <= {bus.alu_result[0], lo[WORD_W-1:1]};
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            busy       <= 1'b0;
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.resp_ready || bus.abort) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    busy       <= 1'b0;
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = resp_valid;
    assign bus.busy       = busy;
    assign bus.prod_hi    = hi;
    assign bus.prod_lo    = lo;

    // The datapath mux only listens while busy, but the drive is parked at zero otherwise.
    assign bus.alu_op     = ALU_ADD;
    assign bus.alu_port_a = (state == RUN) ? hi : '0;
    assign bus.alu_port_b = ((state == RUN) && lo[0]) ? mcand : '0;
endmodule

// File: tb/tb_alu_mult_seq.sv
// Scoreboarded bench for alu_mult_seq with a behavioural single-cycle adder as the ALU.
module tb_alu_mult_seq;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [2*W-1:0] sb[$];

    alu_mult_seq_if #(.WORD_W(W)) bus ();

    alu_mult_seq #(.WORD_W(W), .ITER(W)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
    );

    assign {bus.alu_overflow, bus.alu_result} = {1'b0, bus.alu_port_a} + {1'b0, bus.alu_port_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: req_ready=%b required 1", name, bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.op_a      = a;
        bus.op_b      = b;
        tick();
        sb.push_back(64'(a) * 64'(b));
        bus.req_valid = 1'b0;
        bus.op_a      = $urandom;
        bus.op_b      = $urandom;
    endtask

    task automatic wait_resp(input string name, input bit chk_b_zero);
        int lat;
        int busy_cnt;
        int b_bad;
        lat = 0; busy_cnt = 0; b_bad = 0;
        while (bus.resp_valid !== 1'b1 && lat < 200) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (chk_b_zero && bus.alu_port_b !== '0) b_bad++;
            tick();
            lat++;
        end
        checks++;
        if (lat != 32) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles required 32", name, lat);
        end
        checks++;
        if (busy_cnt != 32 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: busy cycles=%0d busy_now=%b required 32 and 0", name, busy_cnt, bus.busy);
        end
        if (chk_b_zero) begin
            checks++;
            if (b_bad != 0) begin
                errors++;
                $display("FAIL %s_portb_zero: %0d nonzero cycles required 0", name, b_bad);
            end
        end
    endtask

    task automatic take_resp(input string name);
        logic [2*W-1:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++;
        if ({bus.prod_hi, bus.prod_lo} !== exp) begin
            errors++;
            $display("FAIL %s_product: got %h_%h required %h", name, bus.prod_hi, bus.prod_lo, exp);
        end
        bus.resp_ready = 1'b1;
        tick();
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: resp_valid=%b req_ready=%b required 0 1", name, bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input bit chk_b_zero);
        start_op(name, a, b);
        wait_resp(name, chk_b_zero);
        take_resp(name);
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.prod_hi !== '0 || bus.prod_lo !== '0 || bus.alu_port_a !== '0 ||
            bus.alu_port_b !== '0 || bus.alu_op !== 4'd0) begin
            errors++;
            $display("FAIL %s: rdy=%b vld=%b busy=%b hi=%h lo=%h pa=%h pb=%h op=%h required 1 0 0 0 0 0 0 0",
                     name, bus.req_ready, bus.resp_valid, bus.busy, bus.prod_hi, bus.prod_lo,
                     bus.alu_port_a, bus.alu_port_b, bus.alu_op);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
        bus.abort = 1'b0; bus.resp_ready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        tick();
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_basic();
        run_mul("mul_3x5", 32'd3, 32'd5, 1'b0);
    endtask

    task automatic test_carry();
        run_mul("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_zero_and_msb();
        run_mul("mul_zero", 32'h1234_5678, 32'd0, 1'b1);
        run_mul("mul_msb", 32'h8000_0000, 32'd2, 1'b0);
    endtask

    task automatic test_backpressure();
        int bad;
        bus.resp_ready = 1'b0;
        start_op("hold", 32'hCAFE_0001, 32'h0000_F00D);
        wait_resp("hold", 1'b0);
        bad = 0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.op_a = $urandom; bus.op_b = $urandom;
            if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.busy !== 1'b0 ||
                {bus.prod_hi, bus.prod_lo} !== sb[0]) bad++;
            tick();
        end
        bus.req_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles required 0", bad);
        end
        take_resp("hold");
        run_mul("after_hold", 32'd1000, 32'd1000, 1'b0);
    endtask

    task automatic test_abort();
        int seen;
        start_op("abort", 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (10) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        void'(sb.pop_back());
        checks++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b rdy=%b vld=%b required 0 1 0", bus.busy, bus.req_ready, bus.resp_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.resp_valid === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_resp: resp_valid seen %0d cycles required 0", seen);
        end
        // Abort coincident with an accept in IDLE must not cancel the new operation.
        bus.abort = 1'b1;
        start_op("mul_7x6", 32'd7, 32'd6);
        bus.abort = 1'b0;
        wait_resp("mul_7x6", 1'b0);
        checks++;
        if ({bus.prod_hi, bus.prod_lo} !== 64'd42) begin
            errors++;
            $display("FAIL mul_7x6_value: got %0d required 42", {bus.prod_hi, bus.prod_lo});
        end
        take_resp("mul_7x6");
    endtask

    task automatic test_async_reset();
        int seen;
        start_op("arst", 32'h0F0F_0F0F, 32'h7777_7777);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("arst_immediate");
        void'(sb.pop_back());
        #2 rst_n = 1'b1;
        tick();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.resp_valid === 1'b1 || bus.busy === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL arst_lost: activity %0d cycles required 0", seen);
        end
        run_mul("after_arst", 32'hABCD_EF01, 32'h1020_3040, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_mul("b2b", $urandom, $urandom, 1'b0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_carry();
        test_zero_and_msb();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d entries left required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
- Multi-cycle unsigned 32x32->64 multiply sequencer.
- Performs shift-and-add by driving the shared single-cycle ALU with ALU_ADD for one iteration per clock.
- Sits beside the execute stage and owns the ALU port bundle only while busy; the datapath mux selects its ALU drive when busy=1.
- Valid/ready handshakes on both request and response sides.

Parameters:
- WORD_W, 32: operand width; product is 2*WORD_W.
- ITER, WORD_W: number of add/shift iterations; must equal WORD_W.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- req_valid  in  1  request operands valid
- req_ready  out  1  sequencer can accept a request
- op_a  in  WORD_W  multiplicand
- op_b  in  WORD_W  multiplier
- abort  in  1  synchronous cancel of in-flight operation
- resp_valid  out  1  product valid
- resp_ready  in  1  consumer accepts product
- prod_hi  out  WORD_W  product[63:32]
- prod_lo  out  WORD_W  product[31:0]
- busy  out  1  high in RUN (ALU owned by this block)
- alu_op  out  4  aluop_t driven to ALU
- alu_port_a  out  WORD_W  ALU operand A
- alu_port_b  out  WORD_W  ALU operand B
- alu_result  in  WORD_W  ALU result
- alu_overflow  in  1  ALU carry-out (bit 32 of sum for ALU_ADD)

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: state=IDLE, hi=0, lo=0, mcand=0, count=0, resp_valid=0, busy=0, req_ready=1 (combinational from IDLE).
- States and transitions:
  - IDLE: req_ready=1. On req_valid&&req_ready at an edge: mcand<=op_a, hi<=0, lo<=op_b, count<=0, go RUN.
  - RUN: busy=1, req_ready=0. Each cycle:
    - drive alu_op=ALU_ADD, alu_port_a=hi, alu_port_b = lo[0] ? mcand : 0.
    - At the edge: {hi,lo} <= {alu_overflow, alu_result, lo} >> 1, i.e. hi<={carry,result[31:1]}, lo<={result[0],lo[31:1]}; count<=count+1.
    - When count==ITER-1 at an edge, go DONE.
  - DONE: resp_valid=1, prod_hi=hi, prod_lo=lo held stable. On resp_valid&&resp_ready, go IDLE.
- ALU drive outside RUN: alu_op=ALU_ADD, alu_port_a=0, alu_port_b=0.
- Latency: request accepted at edge E; resp_valid rises after edge E+ITER (32 RUN cycles).
- Back-to-back: no accept in DONE. At least one IDLE cycle separates consecutive operations.
- prod_hi/prod_lo always reflect hi/lo registers, but are meaningful only when resp_valid=1.
- req_valid while not IDLE is ignored; op_a/op_b are sampled only at accept.
- abort: in RUN or DONE, next edge returns to IDLE, resp_valid=0, registers untouched. In IDLE, abort has no effect. If abort and an accept occur in the same IDLE cycle, the accept wins.
- Both resp_ready and abort high in DONE: go IDLE (same result).
- resp_ready without resp_valid is ignored.
- nRST low mid-operation: immediately returns to reset values; the in-flight result is lost and no response is produced.
- The count register is wide enough for ITER-1; the counter never wraps within an operation.

Test Plan:
- Reset, then op_a=3, op_b=5, resp_ready=1 -> resp_valid exactly 32 cycles after accept, prod_hi=0, prod_lo=15, busy high for those 32 cycles.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> prod_hi=0xFFFFFFFE, prod_lo=0x00000001 (exercises carry via alu_overflow).
- op_a=0x12345678, op_b=0 -> product 0, alu_port_b=0 every RUN cycle; then op_a=0x80000000, op_b=2 -> prod_hi=1, prod_lo=0.
- resp_ready held 0 for 10 cycles after resp_valid -> outputs stable, req_ready=0, new req_valid ignored; release -> IDLE next edge, then the next request is accepted.
- abort asserted at RUN cycle 10 -> IDLE next edge, no resp_valid. Follow-up 7*6 -> 42.
- nRST pulsed low asynchronously mid-RUN (between edges) -> all outputs at reset values immediately, req_ready=1. A new request completes correctly.
